// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B controller: one 1-bit full-subtractor cell is reused across
// WIDTH cycles (LSB first), with the borrow carried in a register between bits.

module full_sub (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ cin;
  assign bo = (~a & b) | (~(a ^ b) & cin);

endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] a_sh_r, a_sh_nxt_s;
  logic [WIDTH-1:0] b_sh_r, b_sh_nxt_s;
  logic [WIDTH-1:0] res_sh_r, res_sh_nxt_s;
  logic [WIDTH-1:0] res_shift_s;
  logic             brw_r, brw_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             load_res_s;
  logic             d_s, bo_s;

  logic             busy_r, done_r, borrow_out_r, zero_r;
  logic [WIDTH-1:0] diff_r;

  full_sub u_cell (
    .a   (a_sh_r[0]),
    .b   (b_sh_r[0]),
    .cin (brw_r),
    .d   (d_s),
    .bo  (bo_s)
  );

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign res_shift_s = (res_sh_r >> 1) | (WIDTH'(d_s) << (WIDTH - 1));

  // Next-state and datapath next-value decode.
  always_comb begin
    state_nxt_s  = state_r;
    a_sh_nxt_s   = a_sh_r;
    b_sh_nxt_s   = b_sh_r;
    res_sh_nxt_s = res_sh_r;
    brw_nxt_s    = brw_r;
    cnt_nxt_s    = cnt_r;
    load_res_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          a_sh_nxt_s  = a;
          b_sh_nxt_s  = b;
          brw_nxt_s   = 1'b0;
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        res_sh_nxt_s = res_shift_s;
        brw_nxt_s    = bo_s;
        a_sh_nxt_s   = a_sh_r >> 1;
        b_sh_nxt_s   = b_sh_r >> 1;
        cnt_nxt_s    = cnt_r + CNT_ONE;
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = DONE;
          load_res_s  = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      a_sh_r   <= ZERO_W;
      b_sh_r   <= ZERO_W;
      res_sh_r <= ZERO_W;
      brw_r    <= 1'b0;
      cnt_r    <= CNT_ZERO;
    end else begin
      state_r  <= state_nxt_s;
      a_sh_r   <= a_sh_nxt_s;
      b_sh_r   <= b_sh_nxt_s;
      res_sh_r <= res_sh_nxt_s;
      brw_r    <= brw_nxt_s;
      cnt_r    <= cnt_nxt_s;
    end
  end

  // Output registers; results are captured on the same edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      diff_r       <= ZERO_W;
      borrow_out_r <= 1'b0;
      zero_r       <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == RUN);
      done_r <= (state_nxt_s == DONE);
      if (load_res_s) begin
        diff_r       <= res_shift_s;
        borrow_out_r <= bo_s;
        zero_r       <= (res_shift_s == ZERO_W);
      end
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign diff       = diff_r;
  assign borrow_out = borrow_out_r;
  assign zero       = zero_r;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at WIDTH = 1, 4 and 8.

module tb_serial_sub_ctrl;

  logic clk;
  logic rst_n;

  logic       start1, start4, start8;
  logic [0:0] a1, b1;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       busy1, busy4, busy8, done1, done4, done8;
  logic [0:0] diff1;
  logic [3:0] diff4;
  logic [7:0] diff8;
  logic       brw1, brw4, brw8, zero1, zero4, zero8;

  int         sel;
  logic       busy_m, done_m, brw_m, zero_m;
  logic [7:0] diff_m;

  int n_tests;
  int n_fail;

  serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(brw1), .zero(zero1));
  serial_sub_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(brw4), .zero(zero4));
  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(brw8), .zero(zero8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the selected instance to a common set of observation signals.
  always_comb begin
    busy_m = 1'b0; done_m = 1'b0; brw_m = 1'b0; zero_m = 1'b0; diff_m = 8'h00;
    case (sel)
      1: begin busy_m = busy1; done_m = done1; brw_m = brw1; zero_m = zero1; diff_m = {7'h00, diff1}; end
      4: begin busy_m = busy4; done_m = done4; brw_m = brw4; zero_m = zero4; diff_m = {4'h0, diff4}; end
      8: begin busy_m = busy8; done_m = done8; brw_m = brw8; zero_m = zero8; diff_m = diff8; end
      default: begin busy_m = 1'b0; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [7:0] av, input logic [7:0] bv);
    case (w)
      1: begin start1 = st; a1 = av[0:0]; b1 = bv[0:0]; end
      4: begin start4 = st; a4 = av[3:0]; b4 = bv[3:0]; end
      8: begin start8 = st; a8 = av;      b8 = bv;      end
      default: begin end
    endcase
  endtask

  // Advance at least one negedge, then until done is seen or the budget runs out.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_m && n < 40);
    if (!done_m) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [7:0] ed, input logic eb, input logic ez);
    check({tag, "_diff"},   {24'h0, diff_m}, {24'h0, ed});
    check({tag, "_borrow"}, {31'h0, brw_m},  {31'h0, eb});
    check({tag, "_zero"},   {31'h0, zero_m}, {31'h0, ez});
  endtask

  task automatic op(input int w, input logic [7:0] av, input logic [7:0] bv, input string tag);
    logic [7:0] mask, am, bm, ed;
    int n;
    mask = (w == 8) ? 8'hFF : ((8'd1 << w) - 8'd1);
    am = av & mask;
    bm = bv & mask;
    ed = (am - bm) & mask;
    sel = w;
    @(negedge clk); drive(w, 1'b1, av, bv);
    @(negedge clk); drive(w, 1'b0, 8'h00, 8'h00);
    check({tag, "_busy_first"}, {31'h0, busy_m}, 32'd1);
    wait_done(tag, n);
    check({tag, "_latency"}, n, w);
    check({tag, "_busy_at_done"}, {31'h0, busy_m}, 32'd0);
    check_result(tag, ed, am < bm, ed == 8'h00);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'h0, done_m}, 32'd0);
    check({tag, "_diff_hold"}, {24'h0, diff_m}, {24'h0, ed});
  endtask

  initial begin
    int n;
    n_tests = 0; n_fail = 0;
    sel = 4;
    rst_n = 1'b0;
    start1 = 1'b0; start4 = 1'b0; start8 = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0; a8 = 8'h00; b8 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy_m}, 32'd0);
    check("rst_done", {31'h0, done_m}, 32'd0);
    check_result("rst", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    op(4, 8'd9, 8'd3, "w4_9m3");
    op(4, 8'd3, 8'd9, "w4_3m9");
    op(4, 8'd5, 8'd5, "w4_5m5");

    // Start re-pulsed mid-run and operands changed: result must be unaffected.
    sel = 4;
    @(negedge clk); drive(4, 1'b1, 8'd9, 8'd3);
    @(negedge clk); drive(4, 1'b0, 8'd9, 8'd3);
    @(negedge clk); drive(4, 1'b1, 8'd0, 8'd0);
    @(negedge clk); drive(4, 1'b0, 8'd15, 8'd15);
    wait_done("ign", n);
    check("ign_latency", n, 32'd2);
    check_result("ign", 8'd6, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("ign_not_queued", {31'h0, busy_m}, 32'd0);

    // Reset during the second RUN cycle.
    @(negedge clk); drive(4, 1'b1, 8'd9, 8'd3);
    @(negedge clk); drive(4, 1'b0, 8'd0, 8'd0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'h0, busy_m}, 32'd0);
    check("mid_rst_done", {31'h0, done_m}, 32'd0);
    check_result("mid_rst", 8'h00, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {31'h0, busy_m}, 32'd0);
    op(4, 8'd7, 8'd2, "w4_7m2");

    op(8, 8'd255, 8'd0, "w8_255m0");
    op(8, 8'd0, 8'd1, "w8_0m1");

    // start held high: back-to-back operations every WIDTH+2 cycles.
    sel = 8;
    @(negedge clk); drive(8, 1'b1, 8'd20, 8'd5);
    @(negedge clk); drive(8, 1'b1, 8'd100, 8'd200);
    wait_done("hold1", n);
    check_result("hold1", 8'd15, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk); drive(8, 1'b1, 8'd7, 8'd7);
    wait_done("hold2", n);
    check("hold_period", n + 2, 32'd10);
    check_result("hold2", 8'd156, 1'b1, 1'b0);
    wait_done("hold3", n);
    check("hold_period3", n, 32'd10);
    check_result("hold3", 8'd0, 1'b0, 1'b1);
    drive(8, 1'b0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    check("hold_stop", {31'h0, busy_m}, 32'd0);

    op(1, 8'd1, 8'd0, "w1_1m0");
    op(1, 8'd0, 8'd1, "w1_0m1");
    op(1, 8'd1, 8'd1, "w1_1m1");

    for (int i = 0; i < 20; i++) begin
      op(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rnd1");
      op(4, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rnd4");
      op(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rnd8");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
